strobe_rx: RTL and testbench
============================

STROBE_RX -- requirements
Module: strobe_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the sample width.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the FIFO entry count; it must be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous clear of the FIFO, flags and counters.
REQ-006 The block SHALL have port en, input, 1 bit: sample strobe; x is valid on every clk edge where en=1.
REQ-007 The block SHALL have port x, input, DATA_W bits: sample data.
REQ-008 The block SHALL have port y, output, DATA_W bits: FIFO head data.
REQ-009 The block SHALL have port y_valid, output, 1 bit: FIFO not empty.
REQ-010 The block SHALL have port y_ready, input, 1 bit: consumer accepts the head.
REQ-011 The block SHALL have port level, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, a strobe was dropped.
REQ-013 The block SHALL have port seq_err, output, 1 bit: sticky flag, a non-consecutive sample was seen.
REQ-014 The block SHALL have port rcnt, output, 16 bits: count of accepted samples.

Function
REQ-015 On each edge with en=1 and clr=0, the block SHALL push x if level<DEPTH, or if level==DEPTH and a pop occurs on the same edge.
REQ-016 When en=1, level==DEPTH and no pop occurs, the block SHALL drop the sample, leave the FIFO unchanged and set overflow.
REQ-017 The block SHALL be first-word-fall-through: y SHALL equal the oldest entry whenever y_valid=1, and y SHALL be a don't-care when y_valid=0.
REQ-018 The block SHALL pop on an edge where y_valid=1 and y_ready=1; y_ready while empty SHALL have no effect.
REQ-019 A sample pushed at edge N SHALL appear as y_valid=1 with y=x in the cycle following edge N, giving one-cycle write-to-read latency.
REQ-020 A simultaneous push and pop SHALL leave level unchanged, including at level==0 (when empty, the pushed sample becomes the head after the edge) and at level==DEPTH.
REQ-021 Read and write pointers SHALL be clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0; level SHALL never exceed DEPTH.
REQ-022 The sequence checker SHALL evaluate every strobe, including dropped ones; the first strobe after reset or clr SHALL only load the expected value.
REQ-023 For each later strobe, if x != expected, seq_err SHALL be set; expected SHALL be loaded with x+1 modulo 2^DATA_W on every strobe, so a wrap from all-ones to 0 is consecutive.
REQ-024 rcnt SHALL increment on each accepted push and SHALL wrap from 0xFFFF to 0x0000.
REQ-025 clr=1 SHALL empty the FIFO, clear overflow, seq_err and rcnt, and re-arm the baseline; a strobe or pop on the same edge SHALL be ignored.
REQ-026 overflow and seq_err SHALL clear only on reset or clr.

Reset
REQ-027 Asserting rst low SHALL immediately force level=0, y_valid=0, overflow=0, seq_err=0, rcnt=0, both pointers to 0 and the checker to un-armed.
REQ-028 A reset during streaming SHALL discard all FIFO contents; FIFO storage itself SHALL need no reset.
REQ-029 The first strobe at or after the first rising edge following deassertion SHALL be treated as the baseline.

Structure
REQ-030 The DEPTH pointer-width constant and the rcnt width (16) SHALL reside in the shared header, alongside the clock/reset/signal macros.
REQ-031 Storage, pointers and level SHALL be implemented in one sub-module, strobe_rx_fifo (parameters DATA_W, DEPTH; push/pop/full/empty ports); the checker, flags and rcnt SHALL stay in strobe_rx.

Verification
REQ-032 Scenario 1: strobe x=0..99 on alternate cycles with y_ready=1 -> y reads 0..99 in order, seq_err=0, overflow=0, rcnt=100, each y_valid one cycle after its strobe.
REQ-033 Scenario 2: y_ready=0, 10 back-to-back strobes x=0..9 (DEPTH=8) -> level=8, overflow=1, rcnt=8; draining returns 0..7.
REQ-034 Scenario 3: strobes x=5,6,8,9 -> seq_err=1 after the strobe of 8, and all four samples are stored.
REQ-035 Scenario 4: with FIFO full, en=1 (x=8) and y_ready=1 on the same edge -> level stays 8, no overflow, 8 becomes the tail.
REQ-036 Scenario 5: strobes x=0xFFFFFFFF then 0x00000000 -> seq_err=0; clr while level=3 and seq_err=1 -> level=0, y_valid=0, flags=0, next strobe x=42 raises no error.
REQ-037 Scenario 6: rst low mid-stream at level=5 -> outputs reach their reset values before the next clk edge; the post-reset strobe x=77 is read back as y=77.

Source files
------------

// File: rtl/strobe_rx_pkg.sv
// Shared constants and types for the strobe receiver: pointer-width helper,
// sample-counter width and the sticky status flag bundle.
package strobe_rx_pkg;

  localparam int RCNT_W = 16;

  // Pointer width for a power-of-two FIFO; DEPTH=2 still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic seq_err;
  } rx_flags_t;

endpackage

// File: rtl/strobe_rx_fifo.sv
// First-word-fall-through FIFO: storage, wrapping pointers and occupancy.
// Storage is not reset; only pointers and level are.
module strobe_rx_fifo
  import strobe_rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       cnt;

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign dout  = mem[rptr];
  assign level = cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

endmodule

// File: rtl/strobe_rx.sv
// Strobed sample receiver: buffers samples in a FWFT FIFO, flags drops and
// non-consecutive samples, and counts accepted pushes.
module strobe_rx
  import strobe_rx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [DATA_W-1:0]      x,
  output logic [DATA_W-1:0]      y,
  output logic                   y_valid,
  input  logic                   y_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   seq_err,
  output logic [RCNT_W-1:0]      rcnt
);

  logic              full, empty, push, pop;
  logic              armed;
  logic [DATA_W-1:0] exp_x;
  rx_flags_t         flags;

  // A full FIFO still accepts when the head leaves on the same edge.
  assign pop  = !empty && y_ready && !clr;
  assign push = en && !clr && (!full || pop);

  strobe_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (x),
    .dout  (y),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign y_valid  = !empty;
  assign overflow = flags.overflow;
  assign seq_err  = flags.seq_err;

  // Checker sees every strobe, dropped or not; first strobe only arms it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      exp_x <= '0;
      flags <= '0;
      rcnt  <= '0;
    end else if (clr) begin
      armed <= 1'b0;
      exp_x <= '0;
      flags <= '0;
      rcnt  <= '0;
    end else begin
      if (en) begin
        armed <= 1'b1;
        exp_x <= x + 1'b1;
        if (armed && (x != exp_x)) flags.seq_err  <= 1'b1;
        if (full && !pop)          flags.overflow <= 1'b1;
      end
      if (push) rcnt <= rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_strobe_rx.sv
// Scoreboard bench for strobe_rx: accepted strobes queue their value, a
// negedge monitor pops and compares on every handshake.
module tb_strobe_rx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst, clr, en, y_ready;
  logic [DATA_W-1:0] x, y;
  logic              y_valid, overflow, seq_err;
  logic [3:0]        level;
  logic [15:0]       rcnt;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q [$];

  strobe_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .x(x), .y(y), .y_valid(y_valid),
    .y_ready(y_ready), .level(level), .overflow(overflow), .seq_err(seq_err),
    .rcnt(rcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a head presented with y_ready high is consumed on the next edge.
  always @(negedge clk) begin
    if (rst === 1'b1 && clr === 1'b0 && y_valid === 1'b1 && y_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", 64'(y), 64'hDEAD_BEEF_0000_0000);
      end else begin
        check("sb_data", 64'(y), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [DATA_W-1:0] v, input bit acc);
    en = 1'b1;
    x  = v;
    if (acc) exp_q.push_back(v);
    tick();
    en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    y_ready = 1'b1;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    y_ready = 1'b0;
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_empty_after"}, 64'(y_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; en = 1'b0; y_ready = 1'b0; x = '0;
    #1;
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(y_valid), 64'd0);
    check("rst_flags", 64'({overflow, seq_err}), 64'd0);
    check("rst_rcnt", 64'(rcnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Scenario 1: alternate-cycle strobes, consumer always ready
    y_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      strobe(DATA_W'(i), 1'b1);
      if (i % 10 == 0) check("s1_latency_valid", 64'(y_valid), 64'd1);
      tick();
    end
    y_ready = 1'b0;
    check("s1_rcnt", 64'(rcnt), 64'd100);
    check("s1_seq_err", 64'(seq_err), 64'd0);
    check("s1_overflow", 64'(overflow), 64'd0);
    check("s1_all_read", 64'(exp_q.size()), 64'd0);

    // Scenario 2: overflow with consumer stalled
    do_clr();
    for (int i = 0; i < 10; i++) strobe(DATA_W'(i), i < 8);
    check("s2_level", 64'(level), 64'd8);
    check("s2_overflow", 64'(overflow), 64'd1);
    check("s2_rcnt", 64'(rcnt), 64'd8);
    check("s2_seq_err", 64'(seq_err), 64'd0);
    drain("s2");
    check("s2_overflow_sticky", 64'(overflow), 64'd1);

    // Scenario 3: gap in sequence, all samples still stored
    do_clr();
    check("s3_clr_overflow", 64'(overflow), 64'd0);
    strobe(32'd5, 1'b1);
    strobe(32'd6, 1'b1);
    check("s3_no_err_yet", 64'(seq_err), 64'd0);
    strobe(32'd8, 1'b1);
    check("s3_seq_err", 64'(seq_err), 64'd1);
    strobe(32'd9, 1'b1);
    check("s3_level", 64'(level), 64'd4);
    drain("s3");

    // Scenario 4: push into full FIFO while head leaves
    do_clr();
    for (int i = 0; i < 8; i++) strobe(DATA_W'(i), 1'b1);
    check("s4_full", 64'(level), 64'd8);
    y_ready = 1'b1;
    strobe(32'd8, 1'b1);
    y_ready = 1'b0;
    check("s4_level", 64'(level), 64'd8);
    check("s4_overflow", 64'(overflow), 64'd0);
    check("s4_rcnt", 64'(rcnt), 64'd9);
    drain("s4");

    // Scenario 5: all-ones wrap is consecutive; clr wipes state
    do_clr();
    strobe(32'hFFFF_FFFF, 1'b1);
    strobe(32'h0000_0000, 1'b1);
    check("s5_wrap_ok", 64'(seq_err), 64'd0);
    strobe(32'd5, 1'b1);
    check("s5_err", 64'(seq_err), 64'd1);
    check("s5_level3", 64'(level), 64'd3);
    // strobe and clr on one edge: strobe ignored
    en = 1'b1; x = 32'd99;
    do_clr();
    en = 1'b0;
    check("s5_clr_level", 64'(level), 64'd0);
    check("s5_clr_valid", 64'(y_valid), 64'd0);
    check("s5_clr_flags", 64'({overflow, seq_err}), 64'd0);
    check("s5_clr_rcnt", 64'(rcnt), 64'd0);
    strobe(32'd42, 1'b1);
    check("s5_baseline", 64'(seq_err), 64'd0);
    strobe(32'd43, 1'b1);
    check("s5_next_ok", 64'(seq_err), 64'd0);
    check("s5_rcnt", 64'(rcnt), 64'd2);
    drain("s5");

    // Scenario 6: asynchronous reset mid-stream
    do_clr();
    strobe(32'd10, 1'b1);
    strobe(32'd11, 1'b1);
    strobe(32'd12, 1'b1);
    strobe(32'd13, 1'b1);
    strobe(32'd20, 1'b1);
    check("s6_level5", 64'(level), 64'd5);
    check("s6_err_pre", 64'(seq_err), 64'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("s6_rst_level", 64'(level), 64'd0);
    check("s6_rst_valid", 64'(y_valid), 64'd0);
    check("s6_rst_flags", 64'({overflow, seq_err}), 64'd0);
    check("s6_rst_rcnt", 64'(rcnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    strobe(32'd77, 1'b1);
    check("s6_valid", 64'(y_valid), 64'd1);
    check("s6_head", 64'(y), 64'd77);
    check("s6_baseline", 64'(seq_err), 64'd0);
    drain("s6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
